imem_boot_loader: RTL and testbench
===================================

# imem_boot_loader

Boot and program-load controller for the single-cycle MIPS32 instruction memory. It accepts a byte stream over a valid/ready handshake, packs the bytes little-endian into 32-bit instructions, and writes them to consecutive word addresses of a writable instruction memory. While loading it owns the memory address port and holds the CPU halted. Afterwards it hands the port to the PC and asserts `cpu_run`.

## Interface
- `MEM_WIDTH`, 32, instruction word width (must be 32).
- `MEM_DEPTH`, 1024, instruction memory depth in words.
- `ADDR_SIZE`, 32, byte-address width of the PC and memory address.
- `LEN_W`, $clog2(MEM_DEPTH)+1, width of the load length.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `load_start`  in  1  one-cycle request to begin a program load.
- `load_len`  in  LEN_W  number of words to load; sampled with `load_start`.
- `run_req`  in  1  one-cycle request to run the already-resident program without loading.
- `byte_data`  in  8  stream byte.
- `byte_valid`  in  1  `byte_data` is valid.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `pc_addr`  in  ADDR_SIZE  CPU PC byte address.
- `imem_addr`  out  ADDR_SIZE  instruction memory byte address; the memory uses bits [ADDR_SIZE-1:2].
- `imem_wdata`  out  MEM_WIDTH  write data.
- `imem_we`  out  1  write enable, one cycle per word.
- `cpu_run`  out  1  PC may advance; PC register holds while low.
- `load_done`  out  1  one-cycle pulse when the load completes.
- `load_err`  out  1  one-cycle pulse when a load request is rejected.

## Operation
- States: IDLE (reset), LOAD, WRITE, RUN.
- Reset values: `cpu_run`=0, `byte_ready`=0, `imem_we`=0, `imem_wdata`=0, `load_done`=0, `load_err`=0, word pointer=0, byte count=0.
- IDLE:
  - `load_start` with 1 ≤ `load_len` ≤ MEM_DEPTH latches the length, clears the pointer and byte count, and goes to LOAD.
  - `load_start` with an out-of-range length pulses `load_err` and stays in IDLE.
  - `run_req` goes to RUN.
  - If both arrive in the same cycle, `load_start` wins.
- LOAD:
  - `byte_ready`=1. Each accepted byte (`byte_valid` && `byte_ready`) k=0..3 goes into bits [8k+7:8k] of the word.
  - On the 4th accepted byte, go to WRITE.
- WRITE:
  - `byte_ready`=0, `imem_we`=1, `imem_wdata` = packed word, `imem_addr` = pointer×4.
  - Then increment the pointer. If pointer+1 == latched length, go to RUN and pulse `load_done`; otherwise return to LOAD.
- RUN:
  - `cpu_run`=1 and `imem_addr` = `pc_addr`.
  - A `load_start` with a valid length drops `cpu_run` and enters LOAD.
  - A `load_start` with an invalid length pulses `load_err` and stays in RUN.
  - `run_req` is ignored.
- Address mux: `imem_addr` = `pc_addr` only in RUN; otherwise {pointer, 2'b00}, zero-extended.
- `byte_valid` outside LOAD is ignored and no byte is consumed.
- `load_start` or `run_req` during LOAD or WRITE is ignored.
- Reset mid-load returns all state to reset values and drops any partial word. Words already written remain in memory, since memory is not reset.

## Timing
- All outputs are registered except `imem_addr`, which is muxed combinationally from state, pointer and `pc_addr`.
- `load_start` sampled at edge 0 puts the block in LOAD in cycle 1.
- At full byte rate, bytes are accepted in cycles 1–4 and the write occurs in cycle 5: 5 cycles per word.
- For N words, the last `imem_we` is in cycle 5N. `load_done` and `cpu_run` are both high in cycle 5N+1.
- `run_req` in IDLE gives `cpu_run`=1 in the next cycle.
- `load_err` is high in the cycle after the rejected request.
- Stalls on `byte_valid` stretch LOAD without losing byte position.

## Structure
- Shared package `mips_pkg` holds:
  - the loader state enum (IDLE, LOAD, WRITE, RUN);
  - constant BYTES_PER_WORD = 4.
- Sub-module `byte_packer`: byte-count register plus 32-bit shift/insert register. It has `clr`, `push` and `byte_in` inputs and `word`/`full` outputs. The FSM, pointer, length check and address mux stay in the top.

## Test plan
- Reset, then `run_req`: `cpu_run` goes 1 in the next cycle; `imem_addr` follows `pc_addr`=0x18; no `imem_we` is ever seen.
- Load 2 words from bytes 20,88,09,01,04,00,11,AC at full rate: writes 0x01098820 @0x0 in cycle 5 and 0xAC110004 @0x4 in cycle 10; `load_done` and `cpu_run` in cycle 11.
- Same load with `byte_valid` dropped for 3 cycles after the 2nd byte: identical words and addresses; completion 3 cycles later.
- `load_len`=0 and `load_len`=MEM_DEPTH+1: each produces one `load_err` pulse; state unchanged and no writes.
- Reset asserted after 6 bytes of a 3-word load: all outputs return to reset values asynchronously; word 0 stays written; a new load restarts at address 0.
- In RUN, `load_start` with `load_len`=1: `cpu_run` is 0 in the next cycle; bytes 01,00,00,00 write 0x00000001 @0x0; `cpu_run` returns to 1 after the write.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: loader state encoding and word-packing constants shared by the boot loader.
package mips_pkg;
    localparam int BYTES_PER_WORD = 4;
    typedef enum logic [1:0] {IDLE, LOAD, WRITE, RUN} loader_state_t;
endpackage

// File: rtl/byte_packer.sv
// byte_packer: collects stream bytes little-endian into one instruction word.
module byte_packer
    import mips_pkg::*;
#(
    parameter int MEM_WIDTH = 32
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 push,
    input  logic [7:0]           byte_in,
    output logic [MEM_WIDTH-1:0] word,
    output logic                 full
);
    logic [1:0]           r_cnt;
    logic [MEM_WIDTH-1:0] r_word;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (clr) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (push) begin
            r_word[{r_cnt, 3'b000} +: 8] <= byte_in;
            r_cnt                        <= r_cnt + 2'd1;
        end
    end
    assign word = r_word;
    // high on the push that completes the word, so the FSM can leave LOAD on that edge
    assign full = push && (r_cnt == 2'(BYTES_PER_WORD - 1));
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: streams bytes into instruction memory, then releases the CPU to run.
module imem_boot_loader
    import mips_pkg::*;
#(
    parameter int MEM_WIDTH = 32,
    parameter int MEM_DEPTH = 1024,
    parameter int ADDR_SIZE = 32,
    parameter int LEN_W     = $clog2(MEM_DEPTH) + 1
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_start,
    input  logic [LEN_W-1:0]     load_len,
    input  logic                 run_req,
    input  logic [7:0]           byte_data,
    input  logic                 byte_valid,
    output logic                 byte_ready,
    input  logic [ADDR_SIZE-1:0] pc_addr,
    output logic [ADDR_SIZE-1:0] imem_addr,
    output logic [MEM_WIDTH-1:0] imem_wdata,
    output logic                 imem_we,
    output logic                 cpu_run,
    output logic                 load_done,
    output logic                 load_err
);
    loader_state_t        r_state;
    logic [LEN_W-1:0]     r_len;
    logic [LEN_W-1:0]     r_ptr;
    logic                 r_byte_ready;
    logic                 r_imem_we;
    logic                 r_cpu_run;
    logic                 r_load_done;
    logic                 r_load_err;
    logic [LEN_W-1:0]     w_ptr_inc;
    logic                 w_len_ok;
    logic                 w_idle_or_run;
    logic                 w_start_ok;
    logic                 w_push;
    logic                 w_clr;
    logic                 w_full;
    logic [MEM_WIDTH-1:0] w_word;

    assign w_len_ok      = (load_len != '0) && (load_len <= LEN_W'(MEM_DEPTH));
    assign w_idle_or_run = (r_state == IDLE) || (r_state == RUN);
    assign w_start_ok    = w_idle_or_run && load_start && w_len_ok;
    assign w_push        = byte_valid && r_byte_ready;
    assign w_clr         = w_start_ok || (r_state == WRITE);
    assign w_ptr_inc     = r_ptr + LEN_W'(1);

    byte_packer #(.MEM_WIDTH(MEM_WIDTH)) u_packer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (w_clr),
        .push    (w_push),
        .byte_in (byte_data),
        .word    (w_word),
        .full    (w_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_len        <= '0;
            r_ptr        <= '0;
            r_byte_ready <= 1'b0;
            r_imem_we    <= 1'b0;
            r_cpu_run    <= 1'b0;
            r_load_done  <= 1'b0;
            r_load_err   <= 1'b0;
        end else begin
            r_load_done <= 1'b0;
            r_load_err  <= w_idle_or_run && load_start && !w_len_ok;
            case (r_state)
                IDLE, RUN: begin
                    // load_start outranks run_req even when its length is rejected
                    if (w_start_ok) begin
                        r_state      <= LOAD;
                        r_len        <= load_len;
                        r_ptr        <= '0;
                        r_byte_ready <= 1'b1;
                        r_cpu_run    <= 1'b0;
                    end else if (run_req && !load_start) begin
                        r_state   <= RUN;
                        r_cpu_run <= 1'b1;
                    end
                end
                LOAD: begin
                    if (w_full) begin
                        r_state      <= WRITE;
                        r_byte_ready <= 1'b0;
                        r_imem_we    <= 1'b1;
                    end
                end
                WRITE: begin
                    r_imem_we <= 1'b0;
                    r_ptr     <= w_ptr_inc;
                    if (w_ptr_inc == r_len) begin
                        r_state     <= RUN;
                        r_cpu_run   <= 1'b1;
                        r_load_done <= 1'b1;
                    end else begin
                        r_state      <= LOAD;
                        r_byte_ready <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign byte_ready = r_byte_ready;
    assign imem_we    = r_imem_we;
    assign imem_wdata = w_word;
    assign cpu_run    = r_cpu_run;
    assign load_done  = r_load_done;
    assign load_err   = r_load_err;
    assign imem_addr  = (r_state == RUN) ? pc_addr : ADDR_SIZE'({r_ptr, 2'b00});
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: random and directed loads scored against a cycle-level stream model.
module tb_imem_boot_loader;
    localparam int DEPTH = 1024;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_start = 1'b0;
    logic [10:0] load_len = '0;
    logic        run_req = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_valid = 1'b0;
    logic [31:0] pc_addr = '0;
    logic        byte_ready;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        imem_we;
    logic        cpu_run;
    logic        load_done;
    logic        load_err;

    imem_boot_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .load_len   (load_len),
        .run_req    (run_req),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .pc_addr    (pc_addr),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .imem_we    (imem_we),
        .cpu_run    (cpu_run),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] addr; logic [31:0] data; int cyc;} wr_t;
    typedef struct {logic [1:0] kind; int cyc;} ev_t;
    wr_t         exp_wr[$];
    ev_t         exp_ev[$];
    wr_t         mw;
    ev_t         me;
    logic [7:0]  stim[$];
    int          st[$];
    logic [31:0] mem [DEPTH];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          t_start = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // memory model plus scoreboard for writes and done/err pulses
    always @(negedge clk) begin
        if (rst_n) begin
            if (imem_we) begin
                mem[imem_addr[11:2]] = imem_wdata;
                if (exp_wr.size() == 0) check("unexpected_we", 1, 0);
                else begin
                    mw = exp_wr.pop_front();
                    check("wr_addr", imem_addr, mw.addr);
                    check("wr_data", imem_wdata, mw.data);
                    check("wr_cycle", cyc, mw.cyc);
                end
            end
            if (load_done || load_err) begin
                if (exp_ev.size() == 0) check("unexpected_pulse", {30'd0, load_err, load_done}, 0);
                else begin
                    me = exp_ev.pop_front();
                    check("pulse_kind", {30'd0, load_err, load_done}, {30'd0, me.kind});
                    check("pulse_cycle", cyc, me.cyc);
                end
                if (load_done) check("done_cpu_run", cpu_run, 1);
            end
            if (cpu_run) check("run_addr", imem_addr, pc_addr);
        end
    end

    task automatic check_reset();
        check("rst_cpu_run", cpu_run, 0);
        check("rst_byte_ready", byte_ready, 0);
        check("rst_we", imem_we, 0);
        check("rst_wdata", imem_wdata, 0);
        check("rst_done", load_done, 0);
        check("rst_err", load_err, 0);
        check("rst_addr", imem_addr, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_reset();
        exp_wr.delete();
        exp_ev.delete();
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && (exp_wr.size() + exp_ev.size()) != 0; k++) begin
            @(posedge clk); #2;
        end
        check("drain", exp_wr.size() + exp_ev.size(), 0);
    endtask

    task automatic fill(input int n);
        stim.delete();
        repeat (4 * n) stim.push_back(8'($urandom));
    endtask

    // mode 0: full rate, 1: random stalls, 2: three idle cycles before byte 2
    task automatic do_load(input int n, input int mode, input bit noise, input int abort_at);
        int t;
        int nb;
        int s;
        logic [31:0] word;
        nb = (abort_at >= 0) ? abort_at : 4 * n;
        st.delete();
        t_start = cyc;
        t = 1;
        for (int i = 0; i < n; i++) begin
            word = '0;
            for (int j = 0; j < 4; j++) begin
                s = (mode == 1) ? int'($urandom_range(0, 2)) : ((mode == 2 && 4 * i + j == 2) ? 3 : 0);
                st.push_back(s);
                t += s + 1;
                word[8 * j +: 8] = stim[4 * i + j];
            end
            if (4 * i + 4 <= nb) exp_wr.push_back('{32'(4 * i), word, t_start + t});
            t++;
        end
        if (nb == 4 * n) exp_ev.push_back('{2'd1, t_start + t});
        load_start = 1'b1;
        load_len = 11'(n);
        @(posedge clk); #2;
        load_start = 1'b0;
        check("start_cpu_run", cpu_run, 0);
        check("start_ready", byte_ready, 1);
        check("start_addr", imem_addr, 0);
        for (int b = 0; b < nb; b++) begin
            for (int k = 0; k < 20 && !byte_ready; k++) begin
                @(posedge clk); #2;
            end
            check("byte_ready", byte_ready, 1);
            repeat (st[b]) begin
                if (noise) begin
                    load_start = 1'b1;
                    load_len = 11'd1;
                    run_req = 1'b1;
                end
                @(posedge clk); #2;
                load_start = 1'b0;
                run_req = 1'b0;
            end
            byte_valid = 1'b1;
            byte_data = stim[b];
            @(posedge clk); #2;
            byte_valid = 1'b0;
            byte_data = 8'($urandom);
        end
        if (abort_at < 0) drain();
    endtask

    task automatic do_err(input logic [10:0] len, input bit with_run);
        logic prev;
        prev = cpu_run;
        t_start = cyc;
        exp_ev.push_back('{2'd2, t_start + 1});
        load_start = 1'b1;
        load_len = len;
        run_req = with_run;
        @(posedge clk); #2;
        load_start = 1'b0;
        run_req = 1'b0;
        check("err_ready", byte_ready, 0);
        check("err_cpu_run", cpu_run, prev);
        drain();
        check("err_stay", cpu_run, prev);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check_reset();
        rst_n = 1'b1;
        @(posedge clk); #2;
        check_reset();
        run_req = 1'b1;
        @(posedge clk); #2;
        run_req = 1'b0;
        check("run_req_cpu_run", cpu_run, 1);
        pc_addr = 32'h18;
        #1;
        check("run_pc", imem_addr, 32'h18);
        repeat (4) begin
            @(posedge clk); #2;
            pc_addr = $urandom & 32'hFFFF_FFFC;
        end

        do_reset();
        stim = '{8'h20, 8'h88, 8'h09, 8'h01, 8'h04, 8'h00, 8'h11, 8'hAC};
        do_load(2, 0, 1'b0, -1);
        check("mem0", mem[0], 32'h0109_8820);
        check("mem1", mem[1], 32'hAC11_0004);
        do_load(2, 2, 1'b1, -1);

        do_err(11'd0, 1'b0);
        do_err(11'd1025, 1'b0);
        do_reset();
        do_err(11'd0, 1'b1);
        do_err(11'd1025, 1'b0);

        fill(3);
        do_load(3, 0, 1'b0, 6);
        rst_n = 1'b0;
        #1;
        check_reset();
        check("abort_pending", exp_wr.size() + exp_ev.size(), 0);
        check("abort_mem0", mem[0], {stim[3], stim[2], stim[1], stim[0]});
        exp_wr.delete();
        exp_ev.delete();
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;
        fill(3);
        do_load(3, 1, 1'b0, -1);

        stim = '{8'h01, 8'h00, 8'h00, 8'h00};
        do_load(1, 0, 1'b0, -1);
        check("len1_mem0", mem[0], 32'h0000_0001);

        repeat (6) begin
            fill(int'($urandom_range(1, 5)));
            do_load(stim.size() / 4, 1, 1'($urandom), -1);
            pc_addr = $urandom;
            @(posedge clk); #2;
        end

        fill(DEPTH);
        do_load(DEPTH, 0, 1'b0, -1);
        check("last_word", mem[DEPTH-1], {stim[4*DEPTH-1], stim[4*DEPTH-2], stim[4*DEPTH-3], stim[4*DEPTH-4]});
        do_err(11'd2047, 1'b0);

        check("final_queues", exp_wr.size() + exp_ev.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
